// File: rtl/spi_matrix_refresh.sv
// ---------------------------------------------------------------------------
// spi_matrix_refresh
//   Keeps an 8x8 LED matrix driver (MAX7219-class) up to date through an SPI
//   master. The CPU writes row bitmaps and a brightness value into local
//   registers. This block sends the power-up init sequence and then sends only
//   the rows and settings that changed. Each update is a 16-bit write frame on
//   the block's own Wishbone master port.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   s_adr_i..s_dat_o    Wishbone slave (CPU side), register map:
//                         0x00 CTRL   [0] enable, [7:4] intensity, [8] reinit
//                         0x04 STATUS [0] busy, [1] init_done (read-only)
//                         0x08..0x24  ROW0..ROW7 [7:0]
//   m_adr_o..m_ack_i    Wishbone master towards the SPI master, one 16-bit
//                       frame {register, data} per transaction
// ---------------------------------------------------------------------------
module spi_matrix_refresh #(
  parameter logic [31:0] SPI_ADR    = 32'h0600_0000,
  parameter logic [2:0]  SCAN_LIMIT = 3'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  s_adr_i,
  input  logic [31:0] s_dat_i,
  input  logic        s_we_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic        m_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Init sequence command for step idx (0..5).
  function automatic logic [15:0] init_cmd(input logic [2:0] idx, input logic [3:0] inten);
    logic [15:0] cmd;
    case (idx)
      3'd0:    cmd = 16'h0C00;                       // shutdown
      3'd1:    cmd = 16'h0F00;                       // display test off
      3'd2:    cmd = 16'h0900;                       // no decode
      3'd3:    cmd = {8'h0B, 5'b00000, SCAN_LIMIT};  // scan limit
      3'd4:    cmd = {8'h0A, 4'h0, inten};           // intensity
      3'd5:    cmd = 16'h0C01;                       // normal operation
      default: cmd = 16'h0C00;                       // unreachable; shutdown is the safe choice
    endcase
    return cmd;
  endfunction

  // Index of the lowest set bit (0 when none set; callers check for zero first).
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_s_ack;
  logic [31:0] r_s_dat;
  logic        r_enable;
  logic [3:0]  r_intensity;
  logic [7:0]  r_rows [8];
  logic [7:0]  r_row_dirty;
  logic        r_int_dirty;
  logic        r_init_done;
  logic        r_reinit_pend;
  logic        r_init_restart;   // reinit seen since the last init LOAD: restart at step 0
  logic [2:0]  r_init_idx;
  logic [2:0]  r_cur_idx;        // init step of the frame currently in flight
  logic        r_cur_init;       // frame in flight belongs to the init sequence
  logic        r_m_stb;
  logic [15:0] r_m_frame;

  logic        w_acc, w_wr, w_ctrl_wr, w_row_wr, w_reinit_wr, w_int_chg;
  logic [3:0]  w_word;
  logic [2:0]  w_row_idx, w_low_idx, w_idx_eff;
  logic [7:0]  w_row_set, w_row_clr;
  logic        w_ack_ev, w_work, w_do_init, w_init_done_ev, w_busy;
  logic        w_load, w_load_init, w_int_clr;
  logic [15:0] w_frame;
  logic [31:0] w_rd_data;
  logic        w_unused_bits;

  assign w_unused_bits = &{1'b0, s_adr_i[1:0], s_dat_i[31:9], s_dat_i[3:1]};

  // CPU access decode; a new access is only accepted while no ack is pending.
  assign w_acc       = s_stb_i & s_cyc_i & ~r_s_ack;
  assign w_wr        = w_acc & s_we_i;
  assign w_word      = s_adr_i[5:2];
  assign w_row_idx   = w_word[2:0] - 3'd2;   // word 2..9 maps to row 0..7
  assign w_ctrl_wr   = w_wr & (w_word == 4'd0);
  assign w_row_wr    = w_wr & (w_word >= 4'd2) & (w_word <= 4'd9);
  assign w_reinit_wr = w_ctrl_wr & s_dat_i[8];
  assign w_int_chg   = w_ctrl_wr & (s_dat_i[7:4] != r_intensity);
  assign w_row_set   = w_row_wr ? (8'd1 << w_row_idx) : 8'd0;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_ack_ev    = (r_state == ST_REQ) & m_ack_i;
  assign w_do_init   = ~r_init_done | r_reinit_pend;
  assign w_work      = w_do_init | r_int_dirty | (r_row_dirty != 8'h00);
  assign w_idx_eff   = r_init_restart ? 3'd0 : r_init_idx;
  assign w_low_idx   = lowest_idx(r_row_dirty);
  // Last init step acknowledged with no restart pending: init is complete.
  assign w_init_done_ev = w_ack_ev & r_cur_init & (r_cur_idx == 3'd5) & ~r_init_restart;

  // Register read multiplexer
  always_comb begin
    w_rd_data = 32'h0000_0000;
    case (w_word)
      4'd0:    w_rd_data = {24'h00_0000, r_intensity, 3'b000, r_enable};
      4'd1:    w_rd_data = {30'h0000_0000, r_init_done, w_busy};
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
               w_rd_data = {24'h00_0000, r_rows[w_row_idx]};
      default: w_rd_data = 32'h0000_0000;
    endcase
  end

  // Next-state logic and command selection
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_init = 1'b0;
    w_int_clr   = 1'b0;
    w_row_clr   = 8'h00;
    w_frame     = 16'h0000;
    case (r_state)
      ST_IDLE: begin
        if (r_enable && w_work) w_state_nxt = ST_LOAD;
        else                    w_state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_do_init) begin
          w_load      = 1'b1;
          w_load_init = 1'b1;
          w_frame     = init_cmd(w_idx_eff, r_intensity);
          w_state_nxt = ST_REQ;
        end else if (r_int_dirty) begin
          w_load      = 1'b1;
          w_int_clr   = 1'b1;
          w_frame     = {8'h0A, 4'h0, r_intensity};
          w_state_nxt = ST_REQ;
        end else if (r_row_dirty != 8'h00) begin
          w_load      = 1'b1;
          w_row_clr   = 8'd1 << w_low_idx;
          w_frame     = {({5'b00000, w_low_idx} + 8'd1), r_rows[w_low_idx]};
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (m_ack_i) w_state_nxt = ST_GAP;
        else         w_state_nxt = ST_REQ;
      end
      ST_GAP: begin
        if (r_enable && w_work) w_state_nxt = ST_LOAD;
        else                    w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Slave acknowledge pulse and read data, both registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ack <= 1'b0;
      r_s_dat <= 32'h0000_0000;
    end else begin
      r_s_ack <= w_acc;
      r_s_dat <= (w_acc && !s_we_i) ? w_rd_data : 32'h0000_0000;
    end
  end

  // Master strobe and latched frame; strobe is high exactly while in REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_stb    <= 1'b0;
      r_m_frame  <= 16'h0000;
      r_cur_init <= 1'b0;
      r_cur_idx  <= 3'd0;
    end else begin
      if (w_load) begin
        r_m_stb    <= 1'b1;
        r_m_frame  <= w_frame;
        r_cur_init <= w_load_init;
        r_cur_idx  <= w_idx_eff;
      end else if (w_ack_ev) begin
        r_m_stb <= 1'b0;
      end
    end
  end

  // CPU-visible settings and row bitmaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable    <= 1'b0;
      r_intensity <= 4'h0;
      for (int i = 0; i < 8; i++) r_rows[i] <= 8'h00;
    end else begin
      if (w_ctrl_wr) begin
        r_enable    <= s_dat_i[0];
        r_intensity <= s_dat_i[7:4];
      end
      if (w_row_wr) r_rows[w_row_idx] <= s_dat_i[7:0];
    end
  end

  // Dirty tracking and init sequencing; a CPU set always wins over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_dirty    <= 8'hFF;
      r_int_dirty    <= 1'b1;
      r_init_done    <= 1'b0;
      r_reinit_pend  <= 1'b0;
      r_init_restart <= 1'b0;
      r_init_idx     <= 3'd0;
    end else begin
      r_row_dirty <= (w_init_done_ev ? 8'hFF : (r_row_dirty & ~w_row_clr)) | w_row_set;

      if (w_int_chg)                       r_int_dirty <= 1'b1;
      else if (w_init_done_ev || w_int_clr) r_int_dirty <= 1'b0;

      if (w_reinit_wr)         r_init_done <= 1'b0;
      else if (w_init_done_ev) r_init_done <= 1'b1;

      if (w_reinit_wr)         r_reinit_pend <= 1'b1;
      else if (w_init_done_ev) r_reinit_pend <= 1'b0;

      // The restart flag makes the next init LOAD use step 0 and stops the
      // in-flight init frame's ack from advancing the step counter.
      if (w_reinit_wr)      r_init_restart <= 1'b1;
      else if (w_load_init) r_init_restart <= 1'b0;

      if (w_ack_ev && r_cur_init && !r_init_restart) begin
        r_init_idx <= (r_cur_idx == 3'd5) ? 3'd0 : (r_cur_idx + 3'd1);
      end
    end
  end

  assign s_ack_o = r_s_ack;
  assign s_dat_o = r_s_dat;
  assign m_adr_o = SPI_ADR;
  assign m_sel_o = 4'b0011;
  assign m_dat_o = {16'h0000, r_m_frame};
  assign m_stb_o = r_m_stb;
  assign m_cyc_o = r_m_stb;
  assign m_we_o  = r_m_stb;

endmodule
